// File: rtl/ariane_pkg.sv
// Shared types for the TLB-miss scheduler: miss entry, FSM states, requester index.
package ariane_pkg;

  localparam int unsigned VLEN       = 39;
  localparam int unsigned ASID_WIDTH = 1;
  localparam int unsigned PAGE_BITS  = 12;
  localparam int unsigned VPN_WIDTH  = VLEN - PAGE_BITS;

  typedef struct packed {
    logic [VLEN-1:0]       vaddr;
    logic [ASID_WIDTH-1:0] asid;
    logic                  store;
  } miss_entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWalk, StDrain} sched_state_e;

  typedef enum logic {REQ_ITLB, REQ_DTLB} req_idx_e;

  // True when the entry translates the same page (VPN and ASID) as the given walk.
  function automatic logic miss_matches(miss_entry_t e, logic [VPN_WIDTH-1:0] vpn,
                                        logic [ASID_WIDTH-1:0] asid);
    return (e.vaddr[VLEN-1:PAGE_BITS] == vpn) && (e.asid == asid);
  endfunction

endpackage

// File: rtl/tlb_miss_fifo.sv
// Two-entry miss FIFO. Supports popping one or two entries (dedup) and a
// simultaneous push; flush empties it. second_match_o flags that the entry
// behind the head translates the same page as the supplied VPN/ASID.
module tlb_miss_fifo
  import ariane_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  miss_entry_t           entry_i,
  input  logic                  pop_i,
  input  logic                  pop2_i,
  input  logic [VPN_WIDTH-1:0]  match_vpn_i,
  input  logic [ASID_WIDTH-1:0] match_asid_i,
  output logic                  full_o,
  output logic                  empty_o,
  output miss_entry_t           head_o,
  output logic                  second_match_o
);

  miss_entry_t [1:0] mem_q, mem_d;
  logic [1:0]        cnt_q, cnt_d;

  // Next-state: flush wins, then pop (one or two), then push into the freed tail.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (pop2_i && cnt_q == 2'd2) begin
        cnt_d = 2'd0;
      end else if (pop_i && cnt_q != 2'd0) begin
        mem_d[0] = mem_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      if (push_i && cnt_d != 2'd2) begin
        mem_d[cnt_d[0]] = entry_i;
        cnt_d           = cnt_d + 2'd1;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign full_o         = (cnt_q == 2'd2);
  assign empty_o        = (cnt_q == 2'd0);
  assign head_o         = mem_q[0];
  assign second_match_o = (cnt_q == 2'd2) && miss_matches(mem_q[1], match_vpn_i, match_asid_i);

endmodule

// File: rtl/tlb_miss_sched.sv
// TLB-miss scheduler: per-requester 2-entry miss queues, round-robin grant,
// one outstanding PTW walk, flush-safe draining of an in-flight walk.
// Optional feature macro: TLB_MISS_SCHED_DEDUP_EN (drop a queued same-page miss
// behind a successfully walked head).
module tlb_miss_sched
  import ariane_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  itlb_miss_valid_i,
  output logic                  itlb_miss_ready_o,
  input  logic [VLEN-1:0]       itlb_miss_vaddr_i,
  input  logic                  dtlb_miss_valid_i,
  output logic                  dtlb_miss_ready_o,
  input  logic [VLEN-1:0]       dtlb_miss_vaddr_i,
  input  logic                  dtlb_miss_store_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  output logic                  walk_req_valid_o,
  input  logic                  walk_req_ready_i,
  output logic [VLEN-1:0]       walk_req_vaddr_o,
  output logic                  walk_req_is_instr_o,
  output logic                  walk_req_store_o,
  output logic [ASID_WIDTH-1:0] walk_req_asid_o,
  input  logic                  walk_done_i,
  input  logic                  walk_error_i,
  output logic                  busy_o
);

`ifdef TLB_MISS_SCHED_DEDUP_EN
  localparam bit DedupEn = 1'b1;
`else
  localparam bit DedupEn = 1'b0;
`endif

  sched_state_e state_q, state_d;
  req_idx_e     grant_q, grant_d, last_grant_q, last_grant_d;
  miss_entry_t  issue_q, issue_d;

  miss_entry_t i_entry, d_entry, i_head, d_head;
  logic        i_full, i_empty, i_match, i_push, i_pop, i_pop2;
  logic        d_full, d_empty, d_match, d_push, d_pop, d_pop2;
  logic        walk_pop, walk_pop2, dedup;

  assign itlb_miss_ready_o = !i_full && !flush_i;
  assign dtlb_miss_ready_o = !d_full && !flush_i;
  assign i_push  = itlb_miss_valid_i && itlb_miss_ready_o;
  assign d_push  = dtlb_miss_valid_i && dtlb_miss_ready_o;
  assign i_entry = '{vaddr: itlb_miss_vaddr_i, asid: asid_i, store: 1'b0};
  assign d_entry = '{vaddr: dtlb_miss_vaddr_i, asid: asid_i, store: dtlb_miss_store_i};

  assign i_pop  = walk_pop  && (grant_q == REQ_ITLB);
  assign i_pop2 = walk_pop2 && (grant_q == REQ_ITLB);
  assign d_pop  = walk_pop  && (grant_q == REQ_DTLB);
  assign d_pop2 = walk_pop2 && (grant_q == REQ_DTLB);

  tlb_miss_fifo u_itlb_fifo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .push_i         (i_push),
    .entry_i        (i_entry),
    .pop_i          (i_pop),
    .pop2_i         (i_pop2),
    .match_vpn_i    (issue_q.vaddr[VLEN-1:PAGE_BITS]),
    .match_asid_i   (issue_q.asid),
    .full_o         (i_full),
    .empty_o        (i_empty),
    .head_o         (i_head),
    .second_match_o (i_match)
  );

  tlb_miss_fifo u_dtlb_fifo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .push_i         (d_push),
    .entry_i        (d_entry),
    .pop_i          (d_pop),
    .pop2_i         (d_pop2),
    .match_vpn_i    (issue_q.vaddr[VLEN-1:PAGE_BITS]),
    .match_asid_i   (issue_q.asid),
    .full_o         (d_full),
    .empty_o        (d_empty),
    .head_o         (d_head),
    .second_match_o (d_match)
  );

  // A successful walk makes the translation resident, so a same-page miss right
  // behind the head would only re-walk the same entry.
  assign dedup = DedupEn && !walk_error_i && ((grant_q == REQ_ITLB) ? i_match : d_match);

  // FSM next-state, grant selection and walk-request valid.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    issue_d          = issue_q;
    walk_pop         = 1'b0;
    walk_pop2        = 1'b0;
    walk_req_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush_i && (!i_empty || !d_empty)) begin
          if (!i_empty && (d_empty || last_grant_q == REQ_DTLB)) grant_d = REQ_ITLB;
          else                                                   grant_d = REQ_DTLB;
          // Head stays queued until the walk completes.
          issue_d = (grant_d == REQ_ITLB) ? i_head : d_head;
          state_d = StIssue;
        end
      end
      StIssue: begin
        walk_req_valid_o = 1'b1;
        if (walk_req_ready_i) state_d = flush_i ? StDrain : StWalk;
        else if (flush_i)     state_d = StIdle;
      end
      StWalk: begin
        if (walk_done_i) begin
          state_d = StIdle;
          if (!flush_i) begin
            walk_pop     = 1'b1;
            walk_pop2    = dedup;
            last_grant_d = grant_q;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Walker still owns an orphaned request; wait it out without side effects.
        if (walk_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, grant and issue-payload registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= REQ_DTLB;
      last_grant_q <= REQ_DTLB;
      issue_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      issue_q      <= issue_d;
    end
  end

  assign walk_req_vaddr_o    = issue_q.vaddr;
  assign walk_req_asid_o     = issue_q.asid;
  assign walk_req_store_o    = issue_q.store;
  assign walk_req_is_instr_o = (grant_q == REQ_ITLB);
  assign busy_o              = (state_q != StIdle) || !i_empty || !d_empty;

endmodule

// File: tb/tb_tlb_miss_sched.sv
// Self-checking bench for tlb_miss_sched: cycle table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_tlb_miss_sched;
  import ariane_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  itlb_miss_valid_i, itlb_miss_ready_o;
  logic [VLEN-1:0]       itlb_miss_vaddr_i;
  logic                  dtlb_miss_valid_i, dtlb_miss_ready_o;
  logic [VLEN-1:0]       dtlb_miss_vaddr_i;
  logic                  dtlb_miss_store_i;
  logic [ASID_WIDTH-1:0] asid_i;
  logic                  walk_req_valid_o, walk_req_ready_i;
  logic [VLEN-1:0]       walk_req_vaddr_o;
  logic                  walk_req_is_instr_o, walk_req_store_o;
  logic [ASID_WIDTH-1:0] walk_req_asid_o;
  logic                  walk_done_i, walk_error_i, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  tlb_miss_sched dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .itlb_miss_valid_i   (itlb_miss_valid_i),
    .itlb_miss_ready_o   (itlb_miss_ready_o),
    .itlb_miss_vaddr_i   (itlb_miss_vaddr_i),
    .dtlb_miss_valid_i   (dtlb_miss_valid_i),
    .dtlb_miss_ready_o   (dtlb_miss_ready_o),
    .dtlb_miss_vaddr_i   (dtlb_miss_vaddr_i),
    .dtlb_miss_store_i   (dtlb_miss_store_i),
    .asid_i              (asid_i),
    .walk_req_valid_o    (walk_req_valid_o),
    .walk_req_ready_i    (walk_req_ready_i),
    .walk_req_vaddr_o    (walk_req_vaddr_o),
    .walk_req_is_instr_o (walk_req_is_instr_o),
    .walk_req_store_o    (walk_req_store_o),
    .walk_req_asid_o     (walk_req_asid_o),
    .walk_done_i         (walk_done_i),
    .walk_error_i        (walk_error_i),
    .busy_o              (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    flush_i = 0; itlb_miss_valid_i = 0; itlb_miss_vaddr_i = '0;
    dtlb_miss_valid_i = 0; dtlb_miss_vaddr_i = '0; dtlb_miss_store_i = 0; asid_i = 1'b1;
    walk_req_ready_i = 0; walk_done_i = 0; walk_error_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
  endtask

  // Wait (bounded) for a walk request, check payload, handshake, then pulse done.
  task automatic serve(input string name, input logic e_instr, input logic [VLEN-1:0] e_va,
                       input logic e_st, input logic err);
    int t = 0;
    while (!walk_req_valid_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    check({name, "_req_seen"}, walk_req_valid_o, 1);
    if (walk_req_valid_o) begin
      check({name, "_instr"}, walk_req_is_instr_o, e_instr);
      check({name, "_vaddr"}, walk_req_vaddr_o, e_va);
      check({name, "_store"}, walk_req_store_o, e_st);
      walk_req_ready_i = 1;
      @(negedge clk_i);
      walk_req_ready_i = 0;
      walk_done_i = 1;
      walk_error_i = err;
      @(negedge clk_i);
      walk_done_i = 0;
      walk_error_i = 0;
    end
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!walk_req_valid_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    check({name, "_req_seen"}, walk_req_valid_o, 1);
  endtask

  typedef struct {
    logic iv; logic dv; logic [VLEN-1:0] va; logic st;
    logic rdy; logic done; logic flush;
    logic e_valid; logic e_busy; logic e_ird; logic e_drd;
    logic chk; logic e_instr; logic [VLEN-1:0] e_va; logic e_st;
  } vec_t;

  localparam logic [VLEN-1:0] IA  = 39'h40_0000_1000;
  localparam logic [VLEN-1:0] IB  = 39'h00_7777_3000;
  localparam logic [VLEN-1:0] DA  = 39'h00_0AB0_2345;
  localparam logic [VLEN-1:0] DA2 = 39'h00_0CD0_5000;

  vec_t vt[15];

  // Reference-model state for the random phase.
  miss_entry_t qi[$], qd[$];
  miss_entry_t pend_i, pend_d, exp_e, first;
  bit m_busy, m_pend, acc_i, acc_d, hs, done_drv, err_drv, exp_rise;
  int m_grant, m_last, wait_cnt;

  function automatic logic [VLEN-1:0] rand_va();
    logic [VLEN-1:0] v = '0;
    v[13:12] = 2'($urandom_range(0, 3));
    v[11:0]  = 12'($urandom);
    v[38]    = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic bit same_page(miss_entry_t a, miss_entry_t b);
    return (a.vaddr >> 12) == (b.vaddr >> 12) && a.asid == b.asid;
  endfunction

  initial begin
    //         iv dv va   st rdy dn fl | val bsy ird drd chk ins e_va st
    vt[0]  = '{1, 0, IA,  0, 1, 0, 0,   0, 0, 1, 1, 0, 0, '0, 0};
    vt[1]  = '{0, 0, '0,  0, 1, 0, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[2]  = '{0, 0, '0,  0, 1, 0, 0,   1, 1, 1, 1, 1, 1, IA, 0};
    vt[3]  = '{0, 0, '0,  0, 1, 1, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[4]  = '{0, 0, '0,  0, 1, 0, 0,   0, 0, 1, 1, 0, 0, '0, 0};
    vt[5]  = '{0, 1, DA,  1, 1, 0, 0,   0, 0, 1, 1, 0, 0, '0, 0};
    vt[6]  = '{0, 0, '0,  0, 1, 0, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[7]  = '{0, 1, DA2, 1, 1, 0, 0,   1, 1, 1, 1, 1, 0, DA, 1};
    vt[8]  = '{0, 0, '0,  0, 1, 0, 1,   0, 1, 0, 0, 0, 0, '0, 0};
    vt[9]  = '{1, 0, IB,  0, 1, 0, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[10] = '{0, 0, '0,  0, 1, 1, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[11] = '{0, 0, '0,  0, 1, 0, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[12] = '{0, 0, '0,  0, 1, 0, 0,   1, 1, 1, 1, 1, 1, IB, 0};
    vt[13] = '{0, 0, '0,  0, 1, 1, 0,   0, 1, 1, 1, 0, 0, '0, 0};
    vt[14] = '{0, 0, '0,  0, 1, 0, 0,   0, 0, 1, 1, 0, 0, '0, 0};

    // Reset values while reset is held.
    clear_inputs();
    rst_i = 1;
    @(negedge clk_i);
    check("rst_valid", walk_req_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_vaddr", walk_req_vaddr_o, 0);
    check("rst_asid", walk_req_asid_o, 0);
    check("rst_instr", walk_req_is_instr_o, 0);
    check("rst_store", walk_req_store_o, 0);
    @(negedge clk_i);
    rst_i = 0;

    // Cycle table: single ITLB miss, then flush during a DTLB walk.
    for (int k = 0; k < 15; k++) begin
      itlb_miss_valid_i = vt[k].iv; itlb_miss_vaddr_i = vt[k].iv ? vt[k].va : '0;
      dtlb_miss_valid_i = vt[k].dv; dtlb_miss_vaddr_i = vt[k].dv ? vt[k].va : '0;
      dtlb_miss_store_i = vt[k].st; walk_req_ready_i = vt[k].rdy;
      walk_done_i = vt[k].done; flush_i = vt[k].flush;
      #1;
      check($sformatf("tbl%0d_valid", k), walk_req_valid_o, vt[k].e_valid);
      check($sformatf("tbl%0d_busy", k), busy_o, vt[k].e_busy);
      check($sformatf("tbl%0d_iready", k), itlb_miss_ready_o, vt[k].e_ird);
      check($sformatf("tbl%0d_dready", k), dtlb_miss_ready_o, vt[k].e_drd);
      if (vt[k].chk) begin
        check($sformatf("tbl%0d_instr", k), walk_req_is_instr_o, vt[k].e_instr);
        check($sformatf("tbl%0d_vaddr", k), walk_req_vaddr_o, vt[k].e_va);
        check($sformatf("tbl%0d_store", k), walk_req_store_o, vt[k].e_st);
        check($sformatf("tbl%0d_asid", k), walk_req_asid_o, 1);
      end
      @(negedge clk_i);
    end
    clear_inputs();

    // Round robin: simultaneous misses, three rounds.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      itlb_miss_valid_i = 1; itlb_miss_vaddr_i = IA + (39'(r) << 12);
      dtlb_miss_valid_i = 1; dtlb_miss_vaddr_i = DA + (39'(r) << 12); dtlb_miss_store_i = 1;
      @(negedge clk_i);
      clear_inputs();
      serve($sformatf("rr%0d_i", r), 1, IA + (39'(r) << 12), 0, 0);
      serve($sformatf("rr%0d_d", r), 0, DA + (39'(r) << 12), 1, 0);
    end

    // Back-pressure: third DTLB miss waits for the first walk to finish.
    do_reset();
    dtlb_miss_valid_i = 1; dtlb_miss_store_i = 1; dtlb_miss_vaddr_i = 39'h1000;
    @(negedge clk_i);
    dtlb_miss_vaddr_i = 39'h2000;
    @(negedge clk_i);
    dtlb_miss_vaddr_i = 39'h3000;
    #1;
    check("bp_ready_full", dtlb_miss_ready_o, 0);
    check("bp_first_issue", walk_req_vaddr_o, 39'h1000);
    walk_req_ready_i = 1;
    @(negedge clk_i);
    walk_req_ready_i = 0;
    #1;
    check("bp_ready_walk", dtlb_miss_ready_o, 0);
    walk_done_i = 1;
    @(negedge clk_i);
    walk_done_i = 0;
    #1;
    check("bp_ready_after_done", dtlb_miss_ready_o, 1);
    @(negedge clk_i);
    dtlb_miss_valid_i = 0;
    serve("bp_second", 0, 39'h2000, 1, 0);
    serve("bp_third", 0, 39'h3000, 1, 0);
    check("bp_idle", busy_o, 0);

    // Flush in ISSUE without ready, then with ready (drain), last grant untouched.
    do_reset();
    itlb_miss_valid_i = 1; itlb_miss_vaddr_i = 39'h5000;
    @(negedge clk_i);
    itlb_miss_valid_i = 0;
    wait_valid("fl_a");
    flush_i = 1;
    #1;
    check("fl_ready_masked", itlb_miss_ready_o, 0);
    @(negedge clk_i);
    flush_i = 0;
    check("fl_issue_drop", walk_req_valid_o, 0);
    check("fl_issue_idle", busy_o, 0);
    itlb_miss_valid_i = 1; itlb_miss_vaddr_i = 39'h6000;
    @(negedge clk_i);
    itlb_miss_valid_i = 0;
    wait_valid("fl_b");
    flush_i = 1; walk_req_ready_i = 1;
    @(negedge clk_i);
    flush_i = 0; walk_req_ready_i = 0;
    check("fl_drain_valid", walk_req_valid_o, 0);
    check("fl_drain_busy", busy_o, 1);
    itlb_miss_valid_i = 1; itlb_miss_vaddr_i = 39'h7000;
    dtlb_miss_valid_i = 1; dtlb_miss_vaddr_i = 39'h8000; dtlb_miss_store_i = 0;
    @(negedge clk_i);
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fl_drain_hold%0d", k), walk_req_valid_o, 0);
      @(negedge clk_i);
    end
    walk_done_i = 1;
    @(negedge clk_i);
    walk_done_i = 0;
    serve("fl_tie_i", 1, 39'h7000, 0, 0);
    serve("fl_tie_d", 0, 39'h8000, 0, 0);

    // Same-page DTLB misses: success vs error completion.
    for (int e = 0; e < 2; e++) begin
      do_reset();
      dtlb_miss_valid_i = 1; dtlb_miss_store_i = 1; dtlb_miss_vaddr_i = 39'h1234;
      @(negedge clk_i);
      dtlb_miss_vaddr_i = 39'h1FF8;
      @(negedge clk_i);
      dtlb_miss_valid_i = 0;
      serve($sformatf("dd%0d_first", e), 0, 39'h1234, 1, 1'(e));
`ifdef TLB_MISS_SCHED_DEDUP_EN
      if (e == 0) begin
        int seen = 0;
        for (int k = 0; k < 6; k++) begin
          if (walk_req_valid_o) seen++;
          @(negedge clk_i);
        end
        check("dd_single_walk", seen, 0);
      end else begin
        serve("dd1_second", 0, 39'h1FF8, 1, 0);
      end
`else
      serve($sformatf("dd%0d_second", e), 0, 39'h1FF8, 1, 0);
`endif
      check($sformatf("dd%0d_idle", e), busy_o, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_busy = 0; m_pend = 0; m_last = 1; m_grant = 0;
    acc_i = 0; acc_d = 0; hs = 0; done_drv = 0; err_drv = 0; wait_cnt = 0;
    qi.delete(); qd.delete();
    for (int c = 0; c < 3000; c++) begin
      exp_rise = 0;
      if (!m_busy) begin
        if (qi.size() > 0 || qd.size() > 0) begin
          if (qi.size() == 0)      m_grant = 1;
          else if (qd.size() == 0) m_grant = 0;
          else                     m_grant = 1 - m_last;
          exp_e = (m_grant == 0) ? qi[0] : qd[0];
          m_busy = 1; m_pend = 1; exp_rise = 1;
        end
      end else begin
        if (m_pend && hs) m_pend = 0;
        if (done_drv) begin
          if (m_grant == 0) begin
            first = qi.pop_front();
`ifdef TLB_MISS_SCHED_DEDUP_EN
            if (!err_drv && qi.size() > 0 && same_page(qi[0], first)) void'(qi.pop_front());
`endif
          end else begin
            first = qd.pop_front();
`ifdef TLB_MISS_SCHED_DEDUP_EN
            if (!err_drv && qd.size() > 0 && same_page(qd[0], first)) void'(qd.pop_front());
`endif
          end
          m_last = m_grant;
          m_busy = 0;
        end
      end
      if (acc_i) qi.push_back(pend_i);
      if (acc_d) qd.push_back(pend_d);

      check("rnd_valid", walk_req_valid_o, m_pend);
      check("rnd_busy", busy_o, m_busy || qi.size() > 0 || qd.size() > 0);
      if (exp_rise) begin
        check("rnd_instr", walk_req_is_instr_o, m_grant == 0);
        check("rnd_vaddr", walk_req_vaddr_o, exp_e.vaddr);
        check("rnd_asid", walk_req_asid_o, exp_e.asid);
        check("rnd_store", walk_req_store_o, exp_e.store);
      end

      itlb_miss_valid_i = ($urandom_range(0, 2) == 0);
      itlb_miss_vaddr_i = rand_va();
      dtlb_miss_valid_i = ($urandom_range(0, 2) == 0);
      dtlb_miss_vaddr_i = rand_va();
      dtlb_miss_store_i = 1'($urandom);
      asid_i = 1'($urandom);
      walk_req_ready_i = 1'($urandom);
      walk_done_i = 0; walk_error_i = 0;
      if (m_busy && !m_pend) begin
        if (wait_cnt == 0) begin
          walk_done_i = 1;
          walk_error_i = 1'($urandom);
          wait_cnt = $urandom_range(0, 4);
        end else begin
          wait_cnt--;
        end
      end
      done_drv = walk_done_i;
      err_drv  = walk_error_i;
      #1;
      check("rnd_iready", itlb_miss_ready_o, qi.size() < 2);
      check("rnd_dready", dtlb_miss_ready_o, qd.size() < 2);
      acc_i  = itlb_miss_valid_i && itlb_miss_ready_o;
      acc_d  = dtlb_miss_valid_i && dtlb_miss_ready_o;
      pend_i = '{vaddr: itlb_miss_vaddr_i, asid: asid_i, store: 1'b0};
      pend_d = '{vaddr: dtlb_miss_vaddr_i, asid: asid_i, store: dtlb_miss_store_i};
      hs     = walk_req_valid_o && walk_req_ready_i;
      @(negedge clk_i);
    end

    // Reset asserted mid-walk clears everything immediately.
    clear_inputs();
    do_reset();
    itlb_miss_valid_i = 1; itlb_miss_vaddr_i = IA;
    @(negedge clk_i);
    itlb_miss_valid_i = 0;
    wait_valid("mr");
    walk_req_ready_i = 1;
    @(negedge clk_i);
    walk_req_ready_i = 0;
    rst_i = 1;
    #1;
    check("mr_busy", busy_o, 0);
    check("mr_vaddr", walk_req_vaddr_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    check("mr_valid", walk_req_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
